// File: rtl/pin_rx.sv
// pin_rx: serial receiver for the pin-level link.
// Recovers 8N1 frames from an idle-high line: one low start bit, 8 data bits
// sent LSB first, then at least one high stop bit. The line is oversampled
// with clk, and each bit is decided by a 3-sample majority vote taken near
// the bit centre.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx        serial line (asynchronous to clk, idle high)
//   dato      last correctly received byte
//   valid     one-cycle strobe, dato updated this cycle
//   frame_err one-cycle strobe, stop bit sampled low
//   busy      high while a frame is being processed (state != IDLE)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a falling edge on the synchronized line
// START     | timing to mid start bit, confirming it is still low
// DATA      | sampling 8 data bits, one per CLK_PER_BIT cycles
// STOP      | sampling the stop bit; deliver byte or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module pin_rx #(
  parameter int CLK_PER_BIT = 868,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dato,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLK_PER_BIT - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             hist_q;
  logic                   vote;
  logic [15:0]            cnt_q;
  logic [2:0]             bitn_q;
  logic [7:0]             shreg_q;

  logic cnt_clr, bitn_clr, do_shift, do_load, do_err;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      hist_q <= {hist_q[1:0], rx_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // hist_q[0] is rx_s from the previous cycle, so IDLE sees a true 1->0 edge.
  // A break that ends in WAIT_IDLE can only leave it once the line is high,
  // so a held-low line yields exactly one framing error.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    bitn_clr = 1'b0;
    do_shift = 1'b0;
    do_load  = 1'b0;
    do_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s && hist_q[0]) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_clr  = 1'b1;
          bitn_clr = 1'b1;
          state_d  = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_clr  = 1'b1;
          do_shift = 1'b1;
          if (bitn_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_clr = 1'b1;
          if (vote) begin
            do_load = 1'b1;
            state_d = IDLE;
          end else begin
            do_err  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bitn_q    <= '0;
      shreg_q   <= '0;
      dato      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_clr || state_q == IDLE || state_q == WAIT_IDLE) cnt_q <= '0;
      else                                                   cnt_q <= cnt_q + 16'd1;

      if (bitn_clr) bitn_q <= '0;
      else if (do_shift) bitn_q <= bitn_q + 3'd1;

      if (do_shift) shreg_q <= {vote, shreg_q[7:1]};
      if (do_load)  dato    <= shreg_q;

      valid     <= do_load;
      frame_err <= do_err;
    end
  end

endmodule

// File: tb/tb_pin_rx.sv
// Directed bench for pin_rx with CLK_PER_BIT=16 (HALF=8), SYNC_STAGES=2.
module tb_pin_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dato;
  logic       valid;
  logic       frame_err;
  logic       busy;

  pin_rx #(.CLK_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .dato(dato), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_n = 0, both_n = 0, long_n = 0;
  int run = 0, maxrun = 0;
  logic prev_valid = 1'b0, prev_fe = 1'b0;
  logic [7:0] vq[$];
  int         vc[$];
  int         c0, c1, c2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs #1 after the edge and log strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      vq.push_back(dato);
      vc.push_back(cyc);
    end
    if (frame_err) fe_n++;
    if (valid && frame_err) both_n++;
    if ((valid && prev_valid) || (frame_err && prev_fe)) long_n++;
    prev_valid = valid;
    prev_fe    = frame_err;
    if (!busy) run++;
    else begin
      if (run > maxrun) maxrun = run;
      run = 0;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, output int start_cyc);
    start_cyc = cyc;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(stop, CPB);
  endtask

  function automatic logic [7:0] vq_at(input int i);
    return (vq.size() > i) ? vq[i] : 8'hxx;
  endfunction

  function automatic int vc_at(input int i);
    return (vc.size() > i) ? vc[i] : -99999;
  endfunction

  initial begin
    bit done;
    int lat;
    logic bseen;

    // Reset
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    chk("rst_dato", dato, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b1, 2 * CPB);

    // 1: single 0xA5 frame, latency from rx pin = 153 + 2 sync cycles
    vq.delete(); vc.delete(); fe_n = 0;
    send_bit(1'b1, CPB);
    send_byte(8'hA5, 1'b1, c0);
    send_bit(1'b1, 2 * CPB);
    chk("t1_count", vq.size(), 1);
    chk("t1_dato", vq_at(0), 8'hA5);
    lat = vc_at(0) - c0;
    chk("t1_latency_154_156", (lat >= 154 && lat <= 156), 1'b1);
    chk("t1_no_ferr", fe_n, 0);

    // 2: back-to-back frames with a single stop bit
    vq.delete(); vc.delete(); run = 0; maxrun = 0;
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'hFF, 1'b1, c1);
    send_byte(8'h5A, 1'b1, c2);
    send_bit(1'b1, 2 * CPB);
    chk("t2_count", vq.size(), 3);
    chk("t2_dato0", vq_at(0), 8'h00);
    chk("t2_dato1", vq_at(1), 8'hFF);
    chk("t2_dato2", vq_at(2), 8'h5A);
    chk("t2_gap01", vc_at(1) - vc_at(0), 160);
    chk("t2_gap12", vc_at(2) - vc_at(1), 160);
    chk("t2_busy_gap_le_bit", (maxrun <= CPB), 1'b1);

    // 3: 3-cycle low glitch rejected, busy drops within HALF+SYNC+1 cycles
    vq.delete(); vc.delete(); fe_n = 0;
    c0 = cyc;
    rx = 1'b0;
    repeat (3) tick();
    bseen = busy;
    rx = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    chk("t3_busy_seen", bseen, 1'b1);
    chk("t3_busy_dropped", done, 1'b1);
    chk("t3_drop_le_11", ((cyc - c0) <= 11), 1'b1);
    send_bit(1'b1, 2 * CPB);
    chk("t3_no_valid", vq.size(), 0);
    chk("t3_no_ferr", fe_n, 0);

    // 4: framing error followed by a 40-bit break, then a clean frame
    vq.delete(); vc.delete(); fe_n = 0;
    send_byte(8'h3C, 1'b0, c0);
    send_bit(1'b0, 40 * CPB);
    send_bit(1'b1, 2 * CPB);
    chk("t4_ferr_once", fe_n, 1);
    chk("t4_no_valid", vq.size(), 0);
    chk("t4_dato_kept", dato, 8'h5A);
    send_byte(8'h81, 1'b1, c0);
    send_bit(1'b1, 2 * CPB);
    chk("t4_next_count", vq.size(), 1);
    chk("t4_next_dato", vq_at(0), 8'h81);
    chk("t4_ferr_total", fe_n, 1);

    // 5: 0x96 with a one-cycle inverted spike in the vote window of each data bit
    vq.delete(); vc.delete();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h96;
      send_bit(d[i], 7);
      send_bit(~d[i], 1);
      send_bit(d[i], 8);
    end
    send_bit(1'b1, 2 * CPB);
    chk("t5_count", vq.size(), 1);
    chk("t5_dato", vq_at(0), 8'h96);

    // 6: reset in the middle of data bit 4, then a fresh 0x42 frame
    vq.delete(); vc.delete(); fe_n = 0;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(1'b1, CPB);
    send_bit(1'b1, CPB / 2);
    chk("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dato", dato, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_valid", valid, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    send_bit(1'b1, 2 * CPB);
    chk("t6_aborted_no_strobe", vq.size() + fe_n, 0);
    send_byte(8'h42, 1'b1, c0);
    send_bit(1'b1, 2 * CPB);
    chk("t6_count", vq.size(), 1);
    chk("t6_dato", vq_at(0), 8'h42);

    // Global strobe rules
    chk("never_both", both_n, 0);
    chk("one_cycle_strobes", long_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
